// File: rtl/video_pkg.sv
// Shared definitions for the video pattern source: pattern select encoding
// and the colour-bar palette.
package video_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing.sv
// Raster timing core: h/v counters, active/sync decode and start-of-frame.
// Decode outputs are combinational from the counter state.
module video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_h_last,
  output logic          o_dv,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_sof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

  // Disabled counters park at the origin so the first enabled edge emits sof.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;
  assign o_h_last = w_h_last;
  assign o_dv     = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign o_hs     = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                    (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vs     = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                    (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign o_sof    = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// Video test-pattern source: raster timing plus bars/ramp/checker/solid RGB888.
// Define VIDEO_PATTERN_GEN_MOTION_EN to make ramp and checker scroll per frame.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int CHK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  input  logic [23:0] solid_rgb,
  output logic        dv_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        sof_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BSW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_h_last;
  logic          w_dv;
  logic          w_hs;
  logic          w_vs;
  logic          w_sof;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .o_h_cnt  (w_h_cnt),
    .o_v_cnt  (w_v_cnt),
    .o_h_last (w_h_last),
    .o_dv     (w_dv),
    .o_hs     (w_hs),
    .o_vs     (w_vs),
    .o_sof    (w_sof)
  );

  // Bar index tracks h_cnt without a divider: a BAR_W-wide sub-counter steps it.
  logic [BSW-1:0] r_bar_sub;
  logic [2:0]     r_bar_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bar_sub <= '0;
      r_bar_idx <= '0;
    end else if (!en || w_h_last) begin
      r_bar_sub <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_sub == BSW'(BAR_W - 1)) begin
      r_bar_sub <= '0;
      r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_sub <= r_bar_sub + BSW'(1);
    end
  end

  logic [1:0]  r_pat;
  logic [23:0] r_solid;
  logic [1:0]  w_pat;
  logic [23:0] w_solid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat   <= PAT_BARS;
      r_solid <= '0;
    end else if (w_sof) begin
      r_pat   <= pat_sel;
      r_solid <= solid_rgb;
    end
  end

  // The origin pixel already belongs to the new frame, so it sees the live inputs.
  assign w_pat   = w_sof ? pat_sel   : r_pat;
  assign w_solid = w_sof ? solid_rgb : r_solid;

  logic [7:0] w_ramp;
  logic       w_chk_h;

`ifdef VIDEO_PATTERN_GEN_MOTION_EN
  logic [7:0]    r_frame_cnt;
  logic          w_frame_last;
  logic [HW-1:0] w_h_scroll;

  assign w_frame_last = w_h_last && (w_v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (!en) begin
      r_frame_cnt <= '0;
    end else if (w_frame_last) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign w_ramp     = 8'(w_h_cnt) + r_frame_cnt;
  assign w_h_scroll = w_h_cnt + HW'(r_frame_cnt);
  assign w_chk_h    = |(w_h_scroll & (HW'(1) << CHK_LOG2));
`else
  assign w_ramp  = 8'(w_h_cnt);
  assign w_chk_h = w_h_cnt[CHK_LOG2];
`endif

  logic [23:0] w_rgb;

  always_comb begin
    w_rgb = '0;
    case (w_pat)
      PAT_BARS:  w_rgb = bar_color(r_bar_idx);
      PAT_RAMP:  w_rgb = {3{w_ramp}};
      PAT_CHECK: w_rgb = (w_chk_h ^ w_v_cnt[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID: w_rgb = w_solid;
    endcase
  end

  logic        r_dv;
  logic        r_hs;
  logic        r_vs;
  logic        r_sof;
  logic [23:0] r_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dv  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_sof <= 1'b0;
      r_rgb <= '0;
    end else if (!en) begin
      r_dv  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_sof <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_dv  <= w_dv;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_sof <= w_sof;
      r_rgb <= w_dv ? w_rgb : 24'h000000;
    end
  end

  assign dv_o  = r_dv;
  assign hs_o  = r_hs;
  assign vs_o  = r_vs;
  assign sof_o = r_sof;
  assign r_o   = r_rgb[23:16];
  assign g_o   = r_rgb[15:8];
  assign b_o   = r_rgb[7:0];

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Video stream source: generates raster timing (dv/hs/vs) plus RGB888 test patterns.
- Drives the same pixel interface that fir2d consumes; used as filter stimulus on the board and as the bench driver.
- Pattern changes are sampled once per frame, so a frame never mixes two patterns.

Parameters:
- H_ACTIVE, 1280, active pixels per line (must be divisible by 8).
- H_FP, 110, horizontal front porch, in clocks.
- H_SYNC, 40, horizontal sync width, in clocks.
- H_BP, 220, horizontal back porch, in clocks.
- V_ACTIVE, 720, active lines per frame.
- V_FP, 5, vertical front porch, in lines.
- V_SYNC, 5, vertical sync width, in lines.
- V_BP, 20, vertical back porch, in lines.
- CHK_LOG2, 5, log2 of the checkerboard square size.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable.
- pat_sel  in  2  pattern select: 0 = colour bars, 1 = ramp, 2 = checker, 3 = solid.
- solid_rgb  in  24  solid colour, {r,g,b}.
- dv_o  out  1  data valid (active region).
- hs_o  out  1  horizontal sync, active-high.
- vs_o  out  1  vertical sync, active-high.
- r_o  out  8  red.
- g_o  out  8  green.
- b_o  out  8  blue.
- sof_o  out  1  one-cycle pulse with the first active pixel of each frame.

Behaviour:
- Reset: all outputs are 0, h_cnt = v_cnt = 0, bar index = 0, latched pattern = 0.
- Horizontal counter: h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. It wraps to 0.
- Vertical counter: v_cnt increments when h_cnt wraps. It counts 0..V_TOTAL-1 and wraps to 0.
- Region order per axis: active, front porch, sync, back porch. Active is the counter range 0..ACTIVE-1.
- Decode:
  - dv = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs = 1 while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs = 1 for whole lines with V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vs edges align with h_cnt == 0.
- Output stage:
  - All outputs are registered. Latency from counter state to port is exactly 1 clock.
  - dv, hs, vs and RGB are mutually aligned.
  - RGB = 0 whenever dv = 0.
- Pattern latch: pat_sel and solid_rgb are captured only when h_cnt == 0 && v_cnt == 0. Mid-frame changes are ignored until the next frame.
- Colour bars:
  - The bar index (0..7) is advanced by a sub-counter of width H_ACTIVE/8. No divider is used.
  - The index resets to 0 at h_cnt == 0.
  - Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black. Colour bits are 8'hFF or 8'h00.
- Ramp: r = g = b = h_cnt[7:0].
- Checker: each component is 8'hFF if h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2], else 8'h00.
- Solid: outputs the latched solid_rgb.
- sof_o: asserted together with the pixel whose h_cnt == 0 and v_cnt == 0.
- en low:
  - Counters are synchronously forced to 0.
  - On the next edge dv_o, hs_o, vs_o, sof_o and RGB go to 0.
  - Dropping en mid-frame aborts the frame.
- en rising: the counters start at the origin. The first active pixel (with sof_o) appears 1 clock after the first enabled edge.
- Reset asserted mid-frame: outputs are 0 immediately, without waiting for a clock edge. Restart is as for en rising.

Optional Feature:
- Macro: VIDEO_PATTERN_GEN_MOTION_EN.
- When defined:
  - An 8-bit frame counter increments at each frame wrap; it is cleared by rst and by en low.
  - Ramp uses h_cnt[7:0] + frame_cnt.
  - Checker uses (h_cnt + frame_cnt) in place of h_cnt, giving horizontal scroll.
  - Bars are unchanged.
- When undefined: no frame counter exists and patterns are static.

Decomposition:
- Shared package (video_pkg) holds:
  - pattern encoding constants PAT_BARS=0, PAT_RAMP=1, PAT_CHECK=2, PAT_SOLID=3;
  - the 8-entry bar colour table as 24-bit constants.
- Sub-module video_timing: owns the h/v counters, region decode and sof. Reusable elsewhere.
- The top level adds pattern logic and the output registers.

Test Plan:
- Bench parameters for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); CHK_LOG2=1.
- Timing: rst release, en=1 -> per line 16 dv clocks, then 2 idle, hs high for 3, 3 idle; per frame dv on lines 0-3, vs high on lines 5-6; period 192 clocks; sof_o exactly once per 192 clocks.
- Bars: pat_sel=0 -> pixels 0-1 give FFFFFF, 2-3 give FFFF00, 4-5 give 00FFFF, ..., 14-15 give 000000; RGB = 0 during blanking.
- Frame-boundary latch: pat_sel changed 0 to 1 at pixel 5 of line 1 -> the rest of that frame stays bars; next frame ramp r=g=b=0..15 per line.
- Checker/solid: pat_sel=2 -> line 0 pixels 0,1 give 000000, pixels 2,3 give FFFFFF, line 2 inverted; pat_sel=3 with solid_rgb=123456 -> every active pixel is 123456.
- Enable/reset abort: en dropped at line 2 pixel 7 -> all outputs 0 from the next edge; en reasserted -> sof_o 1 clock later. Same check with rst pulsed mid-line: outputs 0 while rst is high, before any clock edge.
- Motion (macro defined, ramp): pixel 0 of the active area reads 00 in frame 0, 01 in frame 1, 02 in frame 2.
